// File: rtl/memory_controller.sv
// memory_controller: first-in-first-out word store with AXI-Stream style ports.
//
// Each stored entry is {data, strb, last}. Write lanes whose strobe bit is 0
// are stored as 0x00, and the strobe itself is stored unchanged. The read side
// is first-word-fall-through: the head entry is shown combinationally while
// m01_axis_tvalid is high. A word written into an empty store appears on the
// read port right after its write edge, never in the same cycle.
//
// Handshake rule, for both ports: a word transfers at a rising edge of aclk
// where tvalid and tready are both 1. The producer holds tvalid and the payload
// steady until that edge. tready and tvalid here depend only on registered
// state and areset, never on the partner's valid or ready, so the two ports
// form no combinational loop.
//
// Ports
//   aclk, areset       clock; synchronous active-high reset
//   s01_axis_tdata     write word
//   s01_axis_tstrb     per-byte write strobe
//   s01_axis_tvalid    write word valid
//   s01_axis_tlast     last word of a frame
//   s01_axis_tready    store can accept a word (count < MEM_SIZE, not in reset)
//   m01_axis_tdata     head word (0 while tvalid = 0)
//   m01_axis_tstrb     strobe stored with the head word
//   m01_axis_tvalid    store holds at least one word (not in reset)
//   m01_axis_tlast     tlast stored with the head word
//   m01_axis_tready    consumer takes the head word
module memory_controller #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = DATA_WIDTH + STRB_W + 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  // Storage carries no reset; the count alone decides which entries are live,
  // so stale words can never be presented with tvalid = 1.
  logic [ENTRY_W-1:0] mem_q [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata_masked;
  logic [ENTRY_W-1:0]    head_entry;

  // A read in the full cycle does not open the write side in that same cycle:
  // readiness looks at the registered count only.
  assign s01_axis_tready = !areset && (count_q < FULL_COUNT);
  assign m01_axis_tvalid = !areset && (count_q != '0);

  assign wr_en = s01_axis_tvalid && s01_axis_tready;
  assign rd_en = m01_axis_tvalid && m01_axis_tready;

  always_comb begin
    wdata_masked = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wdata_masked[b*8 +: 8] = s01_axis_tstrb[b] ? s01_axis_tdata[b*8 +: 8] : 8'h00;
    end
  end

  // Pointers wrap naturally because MEM_SIZE is 2**ADDR_WIDTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // wr_en is already false during reset because tready is forced low.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {wdata_masked, s01_axis_tstrb, s01_axis_tlast};
    end
  end

  assign head_entry = mem_q[rd_ptr_q];

  always_comb begin
    m01_axis_tdata = '0;
    m01_axis_tstrb = '0;
    m01_axis_tlast = 1'b0;
    if (m01_axis_tvalid) begin
      m01_axis_tdata = head_entry[ENTRY_W-1 -: DATA_WIDTH];
      m01_axis_tstrb = head_entry[STRB_W:1];
      m01_axis_tlast = head_entry[0];
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed scenarios plus a randomized phase.
// A queue of {data, strb, last} words stands in for the store; a monitor
// compares the read port against the queue head once per cycle.
module tb_memory_controller;

  localparam int DEPTH = 4096;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int EW    = DW + SW + 1;

  logic          aclk;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;

  int n_vec = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];

  memory_controller #(
    .MEM_SIZE  (DEPTH),
    .ADDR_WIDTH(12),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s01_axis_tdata (s_tdata),
    .s01_axis_tstrb (s_tstrb),
    .s01_axis_tvalid(s_tvalid),
    .s01_axis_tlast (s_tlast),
    .s01_axis_tready(s_tready),
    .m01_axis_tdata (m_tdata),
    .m01_axis_tstrb (m_tstrb),
    .m01_axis_tvalid(m_tvalid),
    .m01_axis_tlast (m_tlast),
    .m01_axis_tready(m_tready)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // What the store should hold for a written word: unstrobed bytes read as 0.
  function automatic logic [EW-1:0] model_entry(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                                input logic l);
    logic [DW-1:0] md;
    md = '0;
    for (int b = 0; b < SW; b++) if (s[b]) md[b*8 +: 8] = d[b*8 +: 8];
    return {md, s, l};
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Sampled mid-cycle: inputs and outputs are stable and decide the next edge.
  always @(negedge aclk) begin
    bit can_wr, can_rd;
    if (areset) begin
      check("rst_s_tready", {63'd0, s_tready}, 64'd0);
      check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      check("rst_m_payload", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
      exp_q.delete();
    end else begin
      can_wr = exp_q.size() < DEPTH;
      can_rd = exp_q.size() > 0;
      check("s_tready", {63'd0, s_tready}, {63'd0, can_wr});
      check("m_tvalid", {63'd0, m_tvalid}, {63'd0, can_rd});
      if (can_rd) begin
        check("m_word", {27'd0, m_tdata, m_tstrb, m_tlast}, {27'd0, exp_q[0]});
        if (m_tready) void'(exp_q.pop_front());
      end else begin
        check("m_idle_payload", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
      end
      if (s_tvalid && can_wr) exp_q.push_back(model_entry(s_tdata, s_tstrb, s_tlast));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    bit done = 0;
    int waited = 0;
    s_tdata  = d;
    s_tstrb  = s;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!done && waited < 100) begin
      @(negedge aclk);
      if (s_tready) done = 1;
      else waited++;
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    if (!done) timeout_fail("send");
  endtask

  task automatic drain();
    bit done = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 3 * DEPTH && !done; c++) begin
      @(posedge aclk);
      if (exp_q.size() == 0) done = 1;
    end
    #1;
    m_tready = 1'b0;
    if (!done) timeout_fail("drain");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bool_init();
    // Reset held 10 cycles.
    repeat (10) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
    check("post_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    idle(1);

    // Single word with consumer stalled, then released.
    send(32'h1234_5678, 4'b1111, 1'b1);
    @(negedge aclk);
    check("single_tvalid", {63'd0, m_tvalid}, 64'd1);
    check("single_tdata", {32'd0, m_tdata}, 64'h1234_5678);
    check("single_tstrb", {60'd0, m_tstrb}, 64'hf);
    check("single_tlast", {63'd0, m_tlast}, 64'd1);
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    @(negedge aclk);
    check("single_drained", {63'd0, m_tvalid}, 64'd0);
    idle(1);

    // Strobe masking.
    send(32'hAABB_CCDD, 4'b0101, 1'b0);
    @(negedge aclk);
    check("strb_tdata", {32'd0, m_tdata}, 64'h00BB_00DD);
    check("strb_tstrb", {60'd0, m_tstrb}, 64'h5);
    drain();

    // Simultaneous write and read at count 1.
    send(32'h0000_0111, 4'hf, 1'b0);
    m_tready = 1'b1;
    send(32'h0000_0222, 4'hf, 1'b1);
    m_tready = 1'b0;
    @(negedge aclk);
    check("simul_tvalid", {63'd0, m_tvalid}, 64'd1);
    check("simul_head", {32'd0, m_tdata}, 64'h0000_0222);
    drain();

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) send(DW'(i), 4'hf, i == DEPTH - 1);
    @(negedge aclk);
    check("full_s_tready", {63'd0, s_tready}, 64'd0);
    // Word 4097 offered but must not be taken.
    @(posedge aclk);
    #1;
    s_tdata  = 32'h0000_0F00;
    s_tstrb  = 4'hf;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("full_blocked", {63'd0, s_tready}, 64'd0);
    end
    // Read while full: write side stays closed in that cycle.
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    @(negedge aclk);
    check("full_rd_no_wr", {63'd0, s_tready}, 64'd0);
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    send(32'h0000_0F00, 4'hf, 1'b0);
    drain();

    // Another 100 words across the pointer wrap.
    for (int i = 0; i < 100; i++) send(32'h0001_0000 + DW'(i), 4'hf, i == 99);
    drain();

    // Mid-operation reset with 10 words stored.
    for (int i = 0; i < 10; i++) send($urandom, 4'hf, 1'b0);
    areset = 1'b1;
    idle(1);
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    idle(1);
    send(32'hCAFE_F00D, 4'hf, 1'b1);
    @(negedge aclk);
    check("midrst_first", {32'd0, m_tdata}, 64'hCAFE_F00D);
    drain();

    // Randomized traffic with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 3));
          send($urandom, SW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          @(posedge aclk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic bool_init();
    areset   = 1'b1;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
  endtask

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter MEM_SIZE, default 4096, SHALL set storage depth in words.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set pointer width; MEM_SIZE SHALL equal 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set word width; must be a multiple of 8.
REQ-004 aclk  input  1  SHALL be the single clock; all logic rising-edge triggered.
REQ-005 areset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 s01_axis_tdata  input  DATA_WIDTH  SHALL carry the write word.
REQ-007 s01_axis_tstrb  input  DATA_WIDTH/8  SHALL carry the per-byte write strobe.
REQ-008 s01_axis_tvalid  input  1  SHALL flag a valid write word.
REQ-009 s01_axis_tlast  input  1  SHALL flag the last word of a frame.
REQ-010 s01_axis_tready  output  1  SHALL signal that a write word can be accepted.
REQ-011 m01_axis_tdata  output  DATA_WIDTH  SHALL carry the read word.
REQ-012 m01_axis_tstrb  output  DATA_WIDTH/8  SHALL carry the strobe stored with the read word.
REQ-013 m01_axis_tvalid  output  1  SHALL flag a valid read word.
REQ-014 m01_axis_tlast  output  1  SHALL carry the tlast stored with the read word.
REQ-015 m01_axis_tready  input  1  SHALL signal that the downstream consumer accepts the read word.

Function
REQ-016 Block SHALL be a first-in-first-out store of MEM_SIZE entries. Each entry SHALL be {data, strb, last}.
REQ-017 State SHALL be:
- write pointer wr_ptr, ADDR_WIDTH bits.
- read pointer rd_ptr, ADDR_WIDTH bits.
- occupancy count, ADDR_WIDTH+1 bits.
REQ-018 Write accept SHALL occur at a rising edge with s01_axis_tvalid=1 and s01_axis_tready=1. On accept:
- entry[wr_ptr] stored.
- wr_ptr incremented, wrapping from MEM_SIZE-1 to 0.
REQ-019 On write, byte lanes with tstrb bit = 0 SHALL be stored as 0x00. Stored strb SHALL equal the input tstrb.
REQ-020 s01_axis_tready SHALL be 1 exactly when count < MEM_SIZE and areset = 0.
REQ-021 m01_axis_tvalid SHALL be 1 exactly when count > 0 and areset = 0.
REQ-022 Read path SHALL be first-word-fall-through: m01_axis_tdata/tstrb/tlast SHALL show entry[rd_ptr] combinationally while tvalid = 1. All three SHALL be 0 while tvalid = 0.
REQ-023 Latency: a word accepted at edge N SHALL be visible on the m01 outputs, with tvalid = 1, immediately after edge N when the store was empty.
REQ-024 Read accept SHALL occur at a rising edge with m01_axis_tvalid=1 and m01_axis_tready=1. On read accept, rd_ptr SHALL increment with wrap.
REQ-025 count SHALL update per edge:
- +1 on write-only.
- -1 on read-only.
- unchanged on simultaneous write and read, or on neither.
REQ-026 Full (count = MEM_SIZE): tready = 0. A read in the same cycle SHALL NOT enable a same-cycle write; the freed slot becomes writable at the next cycle.
REQ-027 Empty (count = 0): no bypass. A write SHALL NOT be readable until the following cycle.
REQ-028 m01 outputs SHALL hold stable while tvalid = 1 and tready = 0.
REQ-029 Words SHALL emerge in write order, with their tlast and strb unchanged. Pointer wrap SHALL be invisible at the ports.
REQ-030 A write attempted while tready = 0 SHALL be ignored; the upstream holds the word.

Reset
REQ-031 At any edge with areset = 1 the block SHALL set wr_ptr = 0, rd_ptr = 0, count = 0. This applies mid-transfer; stored data is discarded logically.
REQ-032 While areset = 1:
- s01_axis_tready = 0, m01_axis_tvalid = 0.
- m01_axis_tdata/tstrb/tlast = 0.
- No write or read SHALL be accepted.
REQ-033 Memory contents need no reset. Stale contents SHALL never appear on m01 with tvalid = 1.

Verification
REQ-034 Reset: hold areset = 1 for 10 cycles, then release. Required: tready = 0 and m tvalid = 0 during reset; after release s tready = 1 and m tvalid = 0.
REQ-035 Single word: write 0x12345678, strb 4'b1111, tlast 1, with m tready = 0. Required: next cycle m tvalid = 1, tdata = 0x12345678, tstrb = 1111, tlast = 1. Then raise m tready = 1; required: after one edge, tvalid = 0.
REQ-036 Strobe: write 0xAABBCCDD with strb 4'b0101. Required read: 0x00BB00DD, tstrb 0101.
REQ-037 Full/wrap: with m tready = 0, write 4096 words data = i, tlast on i = 4095.
- Required: s tready = 0 after the 4096th accept, and the 4097th word is not accepted.
- Then read all: data 0..4095 in order, tlast only on 4095.
- Repeat 100 words to check pointer wrap.
REQ-038 Simultaneous: with count = 1, write and read in the same cycle. Required: count stays 1 and order is preserved. Full case: a read at count = 4096 leaves tready = 0 that cycle.
REQ-039 Mid-operation reset: with count = 10, pulse areset for 1 cycle. Required: m tvalid = 0 afterward. The next written word 0xCAFEF00D is the first read word.
